ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage pipeline, sitting directly downstream of the ID/EX register and feeding the MEM stage. It decodes the ALU operation from the registered ALUOp/funct fields, selects the second operand, computes the ALU result, and resolves conditional branches. Results are captured in an internal EX/MEM register that has valid, stall (hold) and flush (bubble) control. Taken branches produce a registered one-cycle redirect pulse with the target address.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  the ID/EX outputs hold a real instruction.
- `pc_i`  in  32  instruction PC.
- `ctrl_ALUOp_i`  in  2  00 = add, 01 = branch compare, 10 = funct-decoded, 11 = add.
- `ctrl_branch_i`  in  1  instruction is a conditional branch.
- `ctrl_mem_to_regs_i`, `ctrl_mem_read_i`, `ctrl_mem_write_i`, `ctrl_regs_write_i`  in  1 each  control passed to MEM/WB.
- `ctrl_alusrc_i`  in  1  1 selects `imme_i` as operand B; 0 selects `regs_rdata2_i`.
- `imme_i`  in  32  sign-extended immediate.
- `funct3_i`  in  3  instr[14:12].
- `funct7_5_i`  in  1  instr[30].
- `regs_rdata1_i`, `regs_rdata2_i`  in  32  rs1 and rs2 values.
- `regs_rd_i`  in  5  destination register.
- `stall_i`  in  1  MEM is not ready. The EX/MEM register holds.
- `flush_i`  in  1  insert a bubble into EX/MEM.
- `valid_o`  out  1  EX/MEM holds a real instruction.
- `alu_result_o`  out  32  registered ALU result.
- `store_data_o`  out  32  registered rs2 value.
- `regs_rd_o`  out  5  registered rd.
- `ctrl_mem_to_regs_o`, `ctrl_mem_read_o`, `ctrl_mem_write_o`, `ctrl_regs_write_o`  out  1 each  registered control.
- `branch_taken_o`  out  1  one-cycle redirect pulse.
- `branch_target_o`  out  32  redirect PC. Meaningful only while `branch_taken_o` = 1.

## Operation
- Operand A is `regs_rdata1_i`. Operand B is `imme_i` when `ctrl_alusrc_i` = 1, otherwise `regs_rdata2_i`.
- ALUOp 00 and 11: A + B.
- ALUOp 01: A − B. The result is written to `alu_result_o` like any other operation.
- ALUOp 10, selected by `funct3_i`:
  - 000: SUB when `funct7_5_i` = 1 and `ctrl_alusrc_i` = 0, otherwise ADD.
  - 001: SLL.
  - 010: SLT, signed. Result is 1 or 0.
  - 011: SLTU. Result is 1 or 0.
  - 100: XOR.
  - 101: SRA when `funct7_5_i` = 1, otherwise SRL.
  - 110: OR.
  - 111: AND.
- All shifts use B[4:0]. Arithmetic wraps modulo 2^32 and no overflow flag is produced.
- Branch condition on rs1 and rs2, selected by `funct3_i`:
  - 000: EQ. 001: NE.
  - 100: LT, signed. 101: GE, signed.
  - 110: LTU. 111: GEU.
  - 010 and 011: never taken.
- Branch target is `pc_i + imme_i`, modulo 2^32.
- "Advance" = `!stall_i && !flush_i`.
- On advance: every EX/MEM output loads from the current inputs, and `valid_o` loads `valid_i`.
  - When `valid_i` = 0, the four ctrl outputs load 0.
- On flush (`flush_i` = 1, regardless of `stall_i`; flush has priority):
  - `valid_o` and the four ctrl outputs become 0.
  - `alu_result_o`, `store_data_o` and `regs_rd_o` hold their values.
- On stall only: all EX/MEM outputs hold.
- `branch_taken_o` loads 1 only on an advance edge where `valid_i` && `ctrl_branch_i` && condition true. On every other edge it loads 0, so it never repeats during a stall.
  - `branch_target_o` loads the target on that same edge and otherwise holds.

## Timing
- Latency is 1 cycle: inputs present before edge N appear on outputs after edge N.
- Reset (asynchronous, `rst_n` = 0): every output is 0, including `valid_o`, `branch_taken_o` and `branch_target_o`. This holds immediately and for as long as `rst_n` is low.
  - Reset mid-stall discards the held instruction.
- Reset release: the first load happens on the first rising edge with `rst_n` = 1.
- The ALU, operand mux and branch compare are purely combinational between the inputs and the register. No input-to-output combinational path exists.
- The upstream ID/EX register and the PC must honour `stall_i` themselves. This block does not buffer a second instruction.
- A branch taken in cycle N (pulse high after edge N) must be answered by the hazard logic asserting `flush_i` and an ID/EX flush for the wrong-path instructions. That answer is not this block's responsibility.

## Test plan
- Reset then ADD: `rst_n` low, then high. Drive ALUOp=10, f3=000, f7_5=0, alusrc=0, rs1=5, rs2=7, rd=3, regs_write=1, valid=1.
  - During reset: all outputs 0.
  - After one edge: `alu_result_o`=12, `regs_rd_o`=3, `ctrl_regs_write_o`=1, `valid_o`=1.
- ADDI with instr[30]=1: alusrc=1, f3=000, f7_5=1, rs1=10, imm=0xFFFFFC00 -> `alu_result_o`=0xFFFFFC0A (add, not sub).
- Shifts: rs1=0x80000000, alusrc=1, imm=4, f3=101.
  - f7_5=1 -> 0xF8000000.
  - f7_5=0 -> 0x08000000.
- Branch: pc=0x100, imm=0xFFFFFFF0, rs1=0xFFFFFFFF, rs2=1.
  - f3=100 (BLT) -> taken, target 0xF0, pulse exactly one cycle.
  - f3=110 (BLTU) -> `branch_taken_o`=0.
  - Same taken BLT with valid=0 -> no pulse.
- Stall: a SW (ALUOp=00, mem_write=1, rs1=0x200, imm=8, rs2=0xAB) is registered, then `stall_i`=1 for 3 cycles while the inputs change.
  - Outputs stay at 0x208 / 0xAB / mem_write=1.
  - A taken branch at the inputs during the stall produces no pulse.
- Flush: `flush_i`=1 together with `stall_i`=1 and a valid LW at the inputs.
  - After the edge: `valid_o`=0 and all ctrl outputs 0.
  - Next cycle with no flush and no stall: the LW loads normally.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs and EX/MEM/redirect outputs of the execute stage
interface ex_stage_if #(parameter int XLEN = 32);
  logic            valid_i;
  logic [XLEN-1:0] pc_i;
  logic [1:0]      ctrl_ALUOp_i;
  logic            ctrl_branch_i;
  logic            ctrl_mem_to_regs_i;
  logic            ctrl_mem_read_i;
  logic            ctrl_mem_write_i;
  logic            ctrl_regs_write_i;
  logic            ctrl_alusrc_i;
  logic [XLEN-1:0] imme_i;
  logic [2:0]      funct3_i;
  logic            funct7_5_i;
  logic [XLEN-1:0] regs_rdata1_i;
  logic [XLEN-1:0] regs_rdata2_i;
  logic [4:0]      regs_rd_i;
  logic            stall_i;
  logic            flush_i;
  logic            valid_o;
  logic [XLEN-1:0] alu_result_o;
  logic [XLEN-1:0] store_data_o;
  logic [4:0]      regs_rd_o;
  logic            ctrl_mem_to_regs_o;
  logic            ctrl_mem_read_o;
  logic            ctrl_mem_write_o;
  logic            ctrl_regs_write_o;
  logic            branch_taken_o;
  logic [XLEN-1:0] branch_target_o;
  modport master (
    output valid_i, pc_i, ctrl_ALUOp_i, ctrl_branch_i, ctrl_mem_to_regs_i, ctrl_mem_read_i,
           ctrl_mem_write_i, ctrl_regs_write_i, ctrl_alusrc_i, imme_i, funct3_i, funct7_5_i,
           regs_rdata1_i, regs_rdata2_i, regs_rd_i, stall_i, flush_i,
    input  valid_o, alu_result_o, store_data_o, regs_rd_o, ctrl_mem_to_regs_o, ctrl_mem_read_o,
           ctrl_mem_write_o, ctrl_regs_write_o, branch_taken_o, branch_target_o
  );
  modport slave (
    input  valid_i, pc_i, ctrl_ALUOp_i, ctrl_branch_i, ctrl_mem_to_regs_i, ctrl_mem_read_i,
           ctrl_mem_write_i, ctrl_regs_write_i, ctrl_alusrc_i, imme_i, funct3_i, funct7_5_i,
           regs_rdata1_i, regs_rdata2_i, regs_rd_i, stall_i, flush_i,
    output valid_o, alu_result_o, store_data_o, regs_rd_o, ctrl_mem_to_regs_o, ctrl_mem_read_o,
           ctrl_mem_write_o, ctrl_regs_write_o, branch_taken_o, branch_target_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: ALU, operand select and branch resolve feeding a stallable/flushable EX/MEM register
module ex_stage #(parameter int XLEN = 32) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);
  logic [XLEN-1:0] a, b, alu;
  logic [4:0]      sh;
  logic            cond, adv;
  assign a   = bus.regs_rdata1_i;
  assign b   = bus.ctrl_alusrc_i ? bus.imme_i : bus.regs_rdata2_i;
  assign sh  = b[4:0];
  assign adv = !bus.stall_i && !bus.flush_i;
  always_comb begin
    alu = a + b;
    if (bus.ctrl_ALUOp_i == 2'b01) alu = a - b;
    else if (bus.ctrl_ALUOp_i == 2'b10)
      case (bus.funct3_i)
        3'b000:  alu = (bus.funct7_5_i && !bus.ctrl_alusrc_i) ? a - b : a + b;
        3'b001:  alu = a << sh;
        3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        3'b011:  alu = {{(XLEN-1){1'b0}}, a < b};
        3'b100:  alu = a ^ b;
        3'b101:  alu = bus.funct7_5_i ? $unsigned($signed(a) >>> sh) : a >> sh;
        3'b110:  alu = a | b;
        default: alu = a & b;
      endcase
  end
  // branches always compare rs1 against rs2, never the immediate
  always_comb begin
    case (bus.funct3_i)
      3'b000:  cond = a == bus.regs_rdata2_i;
      3'b001:  cond = a != bus.regs_rdata2_i;
      3'b100:  cond = $signed(a) < $signed(bus.regs_rdata2_i);
      3'b101:  cond = $signed(a) >= $signed(bus.regs_rdata2_i);
      3'b110:  cond = a < bus.regs_rdata2_i;
      3'b111:  cond = a >= bus.regs_rdata2_i;
      default: cond = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_o            <= 1'b0;
      bus.alu_result_o       <= '0;
      bus.store_data_o       <= '0;
      bus.regs_rd_o          <= '0;
      bus.ctrl_mem_to_regs_o <= 1'b0;
      bus.ctrl_mem_read_o    <= 1'b0;
      bus.ctrl_mem_write_o   <= 1'b0;
      bus.ctrl_regs_write_o  <= 1'b0;
      bus.branch_taken_o     <= 1'b0;
      bus.branch_target_o    <= '0;
    end else begin
      bus.branch_taken_o <= adv && bus.valid_i && bus.ctrl_branch_i && cond;
      if (adv && bus.valid_i && bus.ctrl_branch_i && cond) bus.branch_target_o <= bus.pc_i + bus.imme_i;
      if (bus.flush_i) begin
        bus.valid_o            <= 1'b0;
        bus.ctrl_mem_to_regs_o <= 1'b0;
        bus.ctrl_mem_read_o    <= 1'b0;
        bus.ctrl_mem_write_o   <= 1'b0;
        bus.ctrl_regs_write_o  <= 1'b0;
      end else if (!bus.stall_i) begin
        bus.valid_o            <= bus.valid_i;
        bus.alu_result_o       <= alu;
        bus.store_data_o       <= bus.regs_rdata2_i;
        bus.regs_rd_o          <= bus.regs_rd_i;
        bus.ctrl_mem_to_regs_o <= bus.valid_i && bus.ctrl_mem_to_regs_i;
        bus.ctrl_mem_read_o    <= bus.valid_i && bus.ctrl_mem_read_i;
        bus.ctrl_mem_write_o   <= bus.valid_i && bus.ctrl_mem_write_i;
        bus.ctrl_regs_write_o  <= bus.valid_i && bus.ctrl_regs_write_i;
      end
    end
  end
endmodule
